hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have the ports listed in REQ-002 to REQ-017; one clock; reset is synchronous and active-high.
REQ-002 clk_i  input  1  pipeline clock; all state changes on rising edge.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 IDEX_MemRead_i  input  1  instruction in EX is a load.
REQ-005 IDEX_rd_addr_i  input  5  destination register of the instruction in EX.
REQ-006 IFID_rs1_addr_i  input  5  rs1 of the instruction in ID.
REQ-007 IFID_rs2_addr_i  input  5  rs2 of the instruction in ID.
REQ-008 branch_taken_i  input  1  branch resolved taken in ID.
REQ-009 mem_req_i  input  1  instruction in MEM is a load or store.
REQ-010 mem_hit_i  input  1  data cache hit for the current mem_req_i.
REQ-011 mem_ack_i  input  1  refill/writeback complete; meaningful only in MISS.
REQ-012 pc_write_o  output  1  PC may update.
REQ-013 ifid_write_o  output  1  IF/ID may load.
REQ-014 ifid_flush_o  output  1  clear IF/ID to NOP.
REQ-015 idex_bubble_o  output  1  zero control bits entering ID/EX.
REQ-016 mem_stall_o  output  1  freeze all pipeline registers, including ID/EX.
REQ-017 dmem_req_o  output  1  one-cycle refill request to the data cache.

Function
REQ-018 FSM states SHALL be RUN, MISS; encoding is free.
REQ-019 miss_start = RUN & mem_req_i & ~mem_hit_i.
REQ-020 RUN -> MISS on miss_start; MISS -> RUN on mem_ack_i; otherwise the state holds.
REQ-021 mem_stall_o = miss_start | (MISS & ~mem_ack_i), combinational; the ack cycle SHALL be unstalled.
REQ-022 dmem_req_o SHALL equal miss_start: exactly one cycle per miss, never asserted in MISS.
REQ-023 hazard = IDEX_MemRead_i & (IDEX_rd_addr_i != 0) & (IDEX_rd_addr_i == IFID_rs1_addr_i | IDEX_rd_addr_i == IFID_rs2_addr_i).
REQ-024 If mem_stall_o=1: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0; mem_stall SHALL dominate every other condition.
REQ-025 Else if hazard: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0; branch_taken_i SHALL be ignored that cycle.
REQ-026 Else if branch_taken_i: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, idex_bubble_o=0.
REQ-027 Else: pc_write_o=1, ifid_write_o=1, other outputs 0.
REQ-028 A load-use stall SHALL last exactly one cycle unless it is extended by mem_stall_o.
REQ-029 mem_ack_i in RUN SHALL be ignored; mem_hit_i and mem_ack_i in MISS SHALL be ignored except for the mem_ack_i exit.
REQ-030 Back-to-back misses SHALL be supported: in the ack cycle the state returns to RUN, and a new miss_start in the next cycle re-enters MISS.

Reset
REQ-031 While rst_i=1 at a clock edge, the state SHALL become RUN and counters SHALL clear; this SHALL also abort an in-progress MISS without issuing dmem_req_o.
REQ-032 While rst_i=1, all outputs SHALL be 0, including pc_write_o and ifid_write_o.
REQ-033 In the first cycle after reset release, outputs SHALL follow REQ-024 to REQ-027 from state RUN.

Configuration
REQ-034 With macro HAZARD_CTRL_PERF_CNT_EN defined, the block SHALL add outputs memstall_cnt_o (16 bits) and bubble_cnt_o (16 bits).
REQ-035 memstall_cnt_o SHALL increment on each cycle with mem_stall_o=1; bubble_cnt_o SHALL increment on each cycle with idex_bubble_o=1.
REQ-036 Both counters SHALL saturate at 0xFFFF and clear on reset.
REQ-037 Without the macro, the ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 Load-use: IDEX_MemRead_i=1, rd=5, rs2=5 for 1 cycle -> pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 that cycle; normal operation next cycle.
REQ-039 x0 filter: IDEX_MemRead_i=1, rd=0, rs1=0 -> no bubble; pc_write_o=1.
REQ-040 Miss: mem_req_i=1, mem_hit_i=0 at cycle 0, mem_ack_i=1 at cycle 4 -> dmem_req_o=1 only at cycle 0; mem_stall_o=1 at cycles 0-3 and 0 at cycle 4; state RUN at cycle 5; memstall_cnt_o=4.
REQ-041 Priority: during MISS, drive hazard=1 and branch_taken_i=1 -> only mem_stall_o=1; bubble and flush remain 0.
REQ-042 Branch under hazard: branch_taken_i=1 with hazard=1 -> ifid_flush_o=0; next cycle, with hazard cleared -> ifid_flush_o=1.
REQ-043 Reset mid-miss: assert rst_i at MISS cycle 2 -> next cycle state is RUN, counters are 0, and no dmem_req_o is issued.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / branch / D-cache-miss pipeline hazard controller
// Optional perf counters guarded by HAZARD_CTRL_PERF_CNT_EN.
module hazard_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_rd_addr_i,
    input  logic [4:0]  IFID_rs1_addr_i,
    input  logic [4:0]  IFID_rs2_addr_i,
    input  logic        branch_taken_i,
    input  logic        mem_req_i,
    input  logic        mem_hit_i,
    input  logic        mem_ack_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        ifid_flush_o,
    output logic        idex_bubble_o,
    output logic        mem_stall_o,
`ifdef HAZARD_CTRL_PERF_CNT_EN
    output logic [15:0] memstall_cnt_o,
    output logic [15:0] bubble_cnt_o,
`endif
    output logic        dmem_req_o
);

    typedef enum logic {ST_RUN, ST_MISS} state_t;

    state_t r_state;
    logic   w_miss_start;
    logic   w_mem_stall;
    logic   w_hazard;

    // Everything is gated by rst_i so outputs are all-zero while reset is held.
    assign w_miss_start = ~rst_i & (r_state == ST_RUN) & mem_req_i & ~mem_hit_i;
    assign w_mem_stall  = ~rst_i & (w_miss_start | ((r_state == ST_MISS) & ~mem_ack_i));
    assign w_hazard     = IDEX_MemRead_i & (IDEX_rd_addr_i != 5'd0) &
                          ((IDEX_rd_addr_i == IFID_rs1_addr_i) |
                           (IDEX_rd_addr_i == IFID_rs2_addr_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:  if (w_miss_start) r_state <= ST_MISS;
                ST_MISS: if (mem_ack_i)    r_state <= ST_RUN;
                default:                   r_state <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        mem_stall_o   = w_mem_stall;
        dmem_req_o    = w_miss_start;
        if (rst_i || w_mem_stall) begin
            pc_write_o   = 1'b0;
        end else if (w_hazard) begin
            idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            ifid_flush_o = 1'b1;
        end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
        end
    end

`ifdef HAZARD_CTRL_PERF_CNT_EN
    logic [15:0] r_memstall_cnt;
    logic [15:0] r_bubble_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_memstall_cnt <= 16'd0;
            r_bubble_cnt   <= 16'd0;
        end else begin
            if (mem_stall_o && (r_memstall_cnt != 16'hFFFF))
                r_memstall_cnt <= r_memstall_cnt + 16'd1;
            if (idex_bubble_o && (r_bubble_cnt != 16'hFFFF))
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign memstall_cnt_o = r_memstall_cnt;
    assign bubble_cnt_o   = r_bubble_cnt;
`else
    // Counters absent in this build.
`endif

endmodule
